// File: rtl/ex_mem.sv
// Execute-to-memory pipeline register with stall, bubble and flush handling.
// Also loops the two-cycle multiply-accumulate partial state back to execute.
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

    // ex -> mem boundary; a stalled execute with a running memory stage
    // sends a NOP downstream but keeps the accumulate state alive.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= 1'b0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (!ex_stall) begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            mem_whilo <= ex_whilo;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (!mem_stall) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= 1'b0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage.
- Captures the execute results each cycle: destination register, write enable, write data, HI/LO values and HI/LO write enable.
- Presents those results to the memory-access stage on the next cycle.
- Supports stall, bubble insertion and flush, driven by the central stall controller.
- Also carries the 64-bit partial result and cycle counter for two-cycle multiply-accumulate ops (madd/maddu/msub/msubu) back to the execute stage while execute is stalled.

Parameters:
- DATA_W, 32, width of register data and of HI and LO.
- ADDR_W, 5, width of a register-file address.
- STALL_W, 6, width of the stall vector (pc, if, id, ex, mem, wb).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  stall request per stage; bit 3 = ex, bit 4 = mem.
- flush  in  1  pipeline flush (exception); synchronous, one-cycle pulse.
- ex_wd  in  ADDR_W  destination register address from execute.
- ex_wreg  in  1  destination write enable from execute.
- ex_wdata  in  DATA_W  destination write data from execute.
- ex_hi  in  DATA_W  HI value from execute.
- ex_lo  in  DATA_W  LO value from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- hilo_i  in  2*DATA_W  multiply-accumulate partial product from execute.
- cnt_i  in  2  multiply-accumulate cycle count from execute.
- mem_wd  out  ADDR_W  registered destination address to the memory stage.
- mem_wreg  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_hi  out  DATA_W  registered HI value.
- mem_lo  out  DATA_W  registered LO value.
- mem_whilo  out  1  registered HI/LO write enable.
- hilo_o  out  2*DATA_W  partial product returned to execute.
- cnt_o  out  2  cycle count returned to execute.

Behaviour:
- All outputs are registered and update only on the rising edge of clk.
- No combinational path from any input to any output.
- Latency is one cycle.
- Update priority, highest first: rst, flush, stall cases, normal advance.
- rst=1:
  - mem_wd=0 (NOP register address); mem_wreg=0; mem_wdata=0; mem_hi=0; mem_lo=0; mem_whilo=0.
  - hilo_o=0; cnt_o=0.
- flush=1 (rst=0):
  - Same values as reset on every output.
  - Any in-progress multiply-accumulate is discarded.
- Bubble (stall[3]=1, stall[4]=0):
  - mem_* outputs load the NOP values, so execute stalls and memory advances.
  - hilo_o<=hilo_i; cnt_o<=cnt_i, preserving the accumulate state.
- Hold (stall[3]=1, stall[4]=1):
  - All outputs, including hilo_o and cnt_o, keep their previous values.
- Normal advance (stall[3]=0):
  - mem_wd<=ex_wd; mem_wreg<=ex_wreg; mem_wdata<=ex_wdata; mem_hi<=ex_hi; mem_lo<=ex_lo; mem_whilo<=ex_whilo.
  - hilo_o<=0; cnt_o<=0.
- stall[3]=0 with stall[4]=1 never occurs (the controller guarantees monotone stall vectors). In that case the block treats it as normal advance; no assertion is required.
- The other stall bits are ignored.
- Multiply-accumulate sequence, as seen by this block:
  - Cycle 1: execute asserts the stall and drives hilo_i=product, cnt_i=1. Next cycle cnt_o=1 and hilo_o=product, and mem_* is a bubble.
  - Cycle 2: execute releases the stall and emits the final HI/LO with whilo=1. Next cycle cnt_o=0 and hilo_o=0.
- Reset or flush in the middle of this sequence clears cnt_o to 0, so execute restarts cleanly.
- Widths are passed through unmodified: no sign extension, truncation or arithmetic.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs at random non-zero values -> every output reads 0 after the first edge.
- Pass-through: stall=6'b000000, ex_wd=5'd7, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_hi=32'h1, ex_lo=32'h2, ex_whilo=1 -> these exact values appear on mem_* one cycle later; hilo_o=0, cnt_o=0.
- Bubble: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=1, ex_wreg=1 -> next cycle mem_wreg=0, mem_wd=0, mem_whilo=0, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=1.
- Hold: load mem_wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles while ex_wdata changes every cycle -> mem_wdata stays 32'hA5A5A5A5 and hilo_o/cnt_o are unchanged.
- Flush priority: in the bubble state with cnt_o=1, pulse flush=1 while stall=6'b001111 -> next cycle all outputs are 0, including cnt_o.
- Madd sequence: stall=6'b001111 with cnt_i=1 for one cycle, then stall=0 with ex_hi=32'h3, ex_lo=32'h4, ex_whilo=1 -> cycle+1: cnt_o=1 and mem_* is a bubble; cycle+2: mem_hi=3, mem_lo=4, mem_whilo=1, cnt_o=0.
